// File: rtl/decode_uimm_pipe.sv
// Registered U-type / J-type decoder with a DEPTH-entry valid/ready output buffer.
// Optional feature: define DECODE_PC_TARGET_EN to add out_target (in_pc + imm, stored per entry).

`ifndef ALU_NOP
`define ALU_NOP 5'b00000
`endif
`ifndef LUI
`define LUI 5'b01011
`endif
`ifndef AUIPC
`define AUIPC 5'b01100
`endif

module decode_uimm_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ALU_W = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [ALU_W-1:0] out_alu_control,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_is_jal,
  output logic             out_unsupported
`ifdef DECODE_PC_TARGET_EN
  ,
  output logic [XLEN-1:0]  out_target
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;

  // ---------------------------------------------------------------------------
  // Combinational decode of the offered instruction
  // ---------------------------------------------------------------------------
  logic [6:0]       opcode;
  logic [31:0]      imm_u;
  logic [31:0]      imm_j;
  logic [31:0]      dec_imm32;
  logic [XLEN-1:0]  dec_imm;
  logic [ALU_W-1:0] dec_alu;
  logic             dec_jal;
  logic             dec_unsup;
  logic             dec_use_pc;

  assign opcode = in_instr[6:0];
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};

  always_comb begin
    dec_imm32  = '0;
    dec_alu    = ALU_W'(`ALU_NOP);
    dec_jal    = 1'b0;
    dec_unsup  = 1'b0;
    dec_use_pc = 1'b0;
    case (opcode)
      OpLui: begin
        dec_imm32 = imm_u;
        dec_alu   = ALU_W'(`LUI);
      end
      OpAuipc: begin
        dec_imm32  = imm_u;
        dec_alu    = ALU_W'(`AUIPC);
        dec_use_pc = 1'b1;
      end
      OpJal: begin
        dec_imm32  = imm_j;
        dec_jal    = 1'b1;
        dec_use_pc = 1'b1;
      end
      default: dec_unsup = 1'b1;
    endcase
  end

  // Bit 31 of the 32-bit immediate is replicated up to XLEN.
  assign dec_imm = XLEN'($signed(dec_imm32));

`ifdef DECODE_PC_TARGET_EN
  logic [XLEN-1:0] dec_target;
  assign dec_target = dec_use_pc ? (in_pc + dec_imm) : '0;
`else
  logic unused_use_pc;
  assign unused_use_pc = dec_use_pc;
`endif

  // ---------------------------------------------------------------------------
  // Buffer control
  // ---------------------------------------------------------------------------
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ready_q;
  logic            push;
  logic            pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    ptr_inc = (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // ready_q holds in_ready low during reset and releases it on the first edge after.
  assign in_ready  = ready_q && (count_q < CntW'(DEPTH)) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ready_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  logic [4:0]       rd_q    [DEPTH];
  logic [XLEN-1:0]  imm_q   [DEPTH];
  logic [ALU_W-1:0] alu_q   [DEPTH];
  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic             jal_q   [DEPTH];
  logic             unsup_q [DEPTH];
`ifdef DECODE_PC_TARGET_EN
  logic [XLEN-1:0]  target_q [DEPTH];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]     <= '0;
        imm_q[i]    <= '0;
        alu_q[i]    <= '0;
        pc_q[i]     <= '0;
        jal_q[i]    <= 1'b0;
        unsup_q[i]  <= 1'b0;
`ifdef DECODE_PC_TARGET_EN
        target_q[i] <= '0;
`endif
      end
    end else if (push) begin
      rd_q[wptr_q]     <= in_instr[11:7];
      imm_q[wptr_q]    <= dec_imm;
      alu_q[wptr_q]    <= dec_alu;
      pc_q[wptr_q]     <= in_pc;
      jal_q[wptr_q]    <= dec_jal;
      unsup_q[wptr_q]  <= dec_unsup;
`ifdef DECODE_PC_TARGET_EN
      target_q[wptr_q] <= dec_target;
`endif
    end
  end

  // Head entry drives the outputs; everything reads zero while the buffer is empty.
  always_comb begin
    out_rd          = '0;
    out_imm         = '0;
    out_alu_control = '0;
    out_pc          = '0;
    out_is_jal      = 1'b0;
    out_unsupported = 1'b0;
`ifdef DECODE_PC_TARGET_EN
    out_target      = '0;
`endif
    if (out_valid) begin
      out_rd          = rd_q[rptr_q];
      out_imm         = imm_q[rptr_q];
      out_alu_control = alu_q[rptr_q];
      out_pc          = pc_q[rptr_q];
      out_is_jal      = jal_q[rptr_q];
      out_unsupported = unsup_q[rptr_q];
`ifdef DECODE_PC_TARGET_EN
      out_target      = target_q[rptr_q];
`endif
    end
  end

endmodule

// File: tb/tb_decode_uimm_pipe.sv
// Directed bench for decode_uimm_pipe: XLEN=32 and XLEN=64 instances share all stimulus.

`ifndef ALU_NOP
`define ALU_NOP 5'b00000
`endif
`ifndef LUI
`define LUI 5'b01011
`endif
`ifndef AUIPC
`define AUIPC 5'b01100
`endif

module tb_decode_uimm_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        rdy32, vld32, jal32, uns32;
  logic [4:0]  rd32, alu32;
  logic [31:0] imm32, pc32, tgt32;
  logic        rdy64, vld64, jal64, uns64;
  logic [4:0]  rd64, alu64;
  logic [63:0] imm64, pc64, tgt64;

  int n_checks = 0;
  int n_pass   = 0;

  decode_uimm_pipe #(.XLEN(32), .ALU_W(5), .DEPTH(2)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(vld32), .out_ready(out_ready),
    .out_rd(rd32), .out_imm(imm32), .out_alu_control(alu32), .out_pc(pc32),
    .out_is_jal(jal32), .out_unsupported(uns32)
`ifdef DECODE_PC_TARGET_EN
    , .out_target(tgt32)
`endif
  );

  decode_uimm_pipe #(.XLEN(64), .ALU_W(5), .DEPTH(2)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(vld64), .out_ready(out_ready),
    .out_rd(rd64), .out_imm(imm64), .out_alu_control(alu64), .out_pc(pc64),
    .out_is_jal(jal64), .out_unsupported(uns64)
`ifdef DECODE_PC_TARGET_EN
    , .out_target(tgt64)
`endif
  );

`ifndef DECODE_PC_TARGET_EN
  assign tgt32 = '0;
  assign tgt64 = '0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_lui(input int k);
    mk_lui = (32'(k) << 12) | (32'(k) << 7) | 32'h37;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rdy32 !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", rdy32);
    else n_pass++;
    n_checks++; if (vld32 !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", vld32);
    else n_pass++;
    n_checks++; if (imm64 !== 64'h0) $display("FAIL reset_imm64: got %h want 0", imm64);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (rdy32 !== 1'b0) $display("FAIL reset_rel_ready: got %0b want 0", rdy32);
    else n_pass++;
    step();
    n_checks++; if (rdy32 !== 1'b1) $display("FAIL post_reset_ready: got %0b want 1", rdy32);
    else n_pass++;
    n_checks++; if (rdy64 !== 1'b1) $display("FAIL post_reset_ready64: got %0b want 1", rdy64);
    else n_pass++;
  endtask

  task automatic test_lui();
    out_ready = 1'b1; in_pc = 64'h0; in_instr = 32'h123452B7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    n_checks++; if (vld32 !== 1'b1) $display("FAIL lui_valid: got %0b want 1", vld32);
    else n_pass++;
    n_checks++; if (rd32 !== 5'd5) $display("FAIL lui_rd: got %0d want 5", rd32);
    else n_pass++;
    n_checks++; if (imm32 !== 32'h12345000) $display("FAIL lui_imm: got %h want 12345000", imm32);
    else n_pass++;
    n_checks++; if (alu32 !== `LUI) $display("FAIL lui_alu: got %h want %h", alu32, `LUI);
    else n_pass++;
    n_checks++;
    if (imm64 !== 64'h12345000) $display("FAIL lui_imm64: got %h want 12345000", imm64);
    else n_pass++;
    n_checks++; if (tgt32 !== 32'h0) $display("FAIL lui_target: got %h want 0", tgt32);
    else n_pass++;
    step();
    n_checks++; if (vld32 !== 1'b0) $display("FAIL lui_popped: got %0b want 0", vld32);
    else n_pass++;
  endtask

  task automatic test_auipc();
    in_pc = 64'h1000; in_instr = 32'hFFFFF097; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (imm64 !== 64'hFFFFFFFFFFFFF000)
      $display("FAIL auipc_imm64: got %h want FFFFFFFFFFFFF000", imm64);
    else n_pass++;
    n_checks++; if (alu64 !== `AUIPC) $display("FAIL auipc_alu: got %h want %h", alu64, `AUIPC);
    else n_pass++;
    n_checks++; if (imm32 !== 32'hFFFFF000) $display("FAIL auipc_imm32: got %h want FFFFF000", imm32);
    else n_pass++;
    n_checks++; if (rd64 !== 5'd1 || pc64 !== 64'h1000)
      $display("FAIL auipc_rd_pc: got rd=%0d pc=%h want rd=1 pc=1000", rd64, pc64);
    else n_pass++;
    n_checks++; if (tgt64 !== 64'h0) $display("FAIL auipc_target: got %h want 0", tgt64);
    else n_pass++;
    step();
  endtask

  task automatic test_jal();
    in_pc = 64'h2000; in_instr = 32'hFFDFF0EF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    n_checks++; if (imm32 !== 32'hFFFFFFFC) $display("FAIL jal_imm: got %h want FFFFFFFC", imm32);
    else n_pass++;
    n_checks++;
    if (imm64 !== 64'hFFFFFFFFFFFFFFFC) $display("FAIL jal_imm64: got %h want FFFFFFFFFFFFFFFC", imm64);
    else n_pass++;
    n_checks++; if (jal32 !== 1'b1 || rd32 !== 5'd1)
      $display("FAIL jal_flags: got jal=%0b rd=%0d want jal=1 rd=1", jal32, rd32);
    else n_pass++;
    n_checks++; if (alu32 !== `ALU_NOP) $display("FAIL jal_alu: got %h want %h", alu32, `ALU_NOP);
    else n_pass++;
`ifdef DECODE_PC_TARGET_EN
    n_checks++; if (tgt32 !== 32'h1FFC) $display("FAIL jal_target: got %h want 1FFC", tgt32);
    else n_pass++;
    n_checks++; if (tgt64 !== 64'h1FFC) $display("FAIL jal_target64: got %h want 1FFC", tgt64);
    else n_pass++;
`endif
    step();
  endtask

  task automatic test_unsupported();
    in_pc = 64'h40; in_instr = 32'h00000013; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    n_checks++; if (vld32 !== 1'b1 || uns32 !== 1'b1)
      $display("FAIL unsup_flag: got valid=%0b unsup=%0b want 1 1", vld32, uns32);
    else n_pass++;
    n_checks++; if (alu32 !== `ALU_NOP || imm32 !== 32'h0 || jal32 !== 1'b0)
      $display("FAIL unsup_fields: got alu=%h imm=%h jal=%0b want nop 0 0", alu32, imm32, jal32);
    else n_pass++;
    n_checks++; if (tgt32 !== 32'h0) $display("FAIL unsup_target: got %h want 0", tgt32);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    int idx;
    int exp;
    logic pushed;
    logic popped;
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h0;
    in_instr = mk_lui(1);
    #1;
    n_checks++; if (rdy32 !== 1'b1) $display("FAIL b2b_ready1: got %0b want 1", rdy32);
    else n_pass++;
    step();
    in_instr = mk_lui(2);
    #1;
    n_checks++; if (rdy32 !== 1'b1) $display("FAIL b2b_ready2: got %0b want 1", rdy32);
    else n_pass++;
    step();
    in_instr = mk_lui(3);
    #1;
    n_checks++; if (rdy32 !== 1'b0) $display("FAIL b2b_full: got %0b want 0", rdy32);
    else n_pass++;
    step();
    n_checks++; if (vld32 !== 1'b1 || rd32 !== 5'd1 || rdy32 !== 1'b0)
      $display("FAIL b2b_hold: got valid=%0b rd=%0d ready=%0b want 1 1 0", vld32, rd32, rdy32);
    else n_pass++;
    out_ready = 1'b1;
    idx = 3;
    exp = 1;
    for (int c = 0; c < 30 && exp <= 5; c++) begin
      in_valid = (idx <= 5);
      in_instr = mk_lui(idx);
      #1;
      pushed = in_valid && rdy32;
      popped = vld32 && out_ready;
      if (popped) begin
        n_checks++;
        if (rd32 !== 5'(exp) || imm32 !== (32'(exp) << 12))
          $display("FAIL b2b_order: got rd=%0d imm=%h want rd=%0d imm=%h",
                   rd32, imm32, exp, 32'(exp) << 12);
        else n_pass++;
        exp++;
      end
      step();
      if (pushed) idx++;
    end
    in_valid = 1'b0;
    n_checks++; if (exp != 6) $display("FAIL b2b_timeout: got %0d pops want 5", exp - 1);
    else n_pass++;
    #1;
    n_checks++; if (vld32 !== 1'b0) $display("FAIL b2b_drained: got %0b want 0", vld32);
    else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = mk_lui(6);
    step();
    in_instr = mk_lui(7);
    step();
    in_instr = mk_lui(8); flush = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++; if (rdy32 !== 1'b0) $display("FAIL flush_ready: got %0b want 0", rdy32);
    else n_pass++;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++; if (vld32 !== 1'b0 || rd32 !== 5'd0 || imm32 !== 32'h0)
      $display("FAIL flush_empty: got valid=%0b rd=%0d imm=%h want 0 0 0", vld32, rd32, imm32);
    else n_pass++;
    n_checks++; if (rdy32 !== 1'b1) $display("FAIL flush_ready_after: got %0b want 1", rdy32);
    else n_pass++;
    step();
    n_checks++; if (vld32 !== 1'b0) $display("FAIL flush_dropped: got %0b want 0", vld32);
    else n_pass++;
    in_instr = mk_lui(9); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    n_checks++; if (vld32 !== 1'b1 || rd32 !== 5'd9)
      $display("FAIL flush_refill: got valid=%0b rd=%0d want 1 9", vld32, rd32);
    else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = mk_lui(10);
    step();
    in_instr = mk_lui(11);
    step();
    in_valid = 1'b0;
    #1;
    n_checks++; if (vld32 !== 1'b1 || rd32 !== 5'd10)
      $display("FAIL rstmid_pre: got valid=%0b rd=%0d want 1 10", vld32, rd32);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (vld32 !== 1'b0 || vld64 !== 1'b0 || rd32 !== 5'd0)
      $display("FAIL rstmid_async: got valid=%0b/%0b rd=%0d want 0 0 0", vld32, vld64, rd32);
    else n_pass++;
    n_checks++; if (rdy32 !== 1'b0) $display("FAIL rstmid_ready: got %0b want 0", rdy32);
    else n_pass++;
    #2;
    reset = 1'b0;
    step();
    n_checks++; if (rdy32 !== 1'b1 || vld32 !== 1'b0)
      $display("FAIL rstmid_after: got ready=%0b valid=%0b want 1 0", rdy32, vld32);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lui();
    test_auipc();
    test_jal();
    test_unsupported();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
